// File: rtl/cv_pe_arbiter_pkg.sv
// Shared constants and state encoding for the convolution PE memory arbiter.
package cv_pe_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 26;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Width of a PE index; at least one bit so a 1-entry index still has a vector.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv_pe_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping around.
module rr_pick
    import cv_pe_arbiter_pkg::*;
#(
    parameter int unsigned N_PE  = 4,
    parameter int unsigned PTR_W = ptr_width(N_PE)
) (
    input  logic [N_PE-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_PE-1:0]  sel_oh,
    output logic [PTR_W-1:0] sel_idx,
    output logic             sel_valid
);

    logic [PTR_W:0] idx;

    // Scan N_PE positions starting at ptr; the first hit wins.
    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N_PE; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(N_PE)) begin
                idx = idx - (PTR_W+1)'(N_PE);
            end
            if (!sel_valid && req[idx[PTR_W-1:0]]) begin
                sel_valid                = 1'b1;
                sel_oh[idx[PTR_W-1:0]]   = 1'b1;
                sel_idx                  = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cv_pe_arbiter.sv
// Round-robin arbiter sharing one external memory port among N_PE loaders.
// Optional idle-handshake timeout release: define CV_ARB_TIMEOUT_EN.
module cv_pe_arbiter
    import cv_pe_arbiter_pkg::*;
#(
    parameter int unsigned N_PE    = 4,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PE-1:0]            req,
    input  logic [N_PE*LEN_W-1:0]      req_len,
    input  logic [N_PE-1:0]            pe_wvalid,
    input  logic [N_PE*MEM_ADDR_W-1:0] pe_waddr,
    input  logic [N_PE*MEM_DATA_W-1:0] pe_wdata,
    output logic [N_PE-1:0]            pe_wready,
    input  logic [N_PE-1:0]            pe_rvalid,
    input  logic [N_PE*MEM_ADDR_W-1:0] pe_raddr,
    output logic [N_PE-1:0]            pe_rready,
    output logic [MEM_DATA_W-1:0]      pe_rdata,
    output logic [N_PE-1:0]            grant,
    output logic [N_PE-1:0]            done,
    output logic                       timeout,
    output logic                       busy,
    output logic                       wvalid,
    input  logic                       wready,
    output logic [MEM_ADDR_W-1:0]      waddr,
    output logic [MEM_DATA_W-1:0]      wdata,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [MEM_ADDR_W-1:0]      raddr,
    input  logic [MEM_DATA_W-1:0]      rdata
);

    localparam int unsigned PTR_W = ptr_width(N_PE);

    if (N_PE < 2 || N_PE > 16 || TIMEOUT < 1) begin : g_param_check
        $error("cv_pe_arbiter: N_PE must be 2..16 and TIMEOUT at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [N_PE-1:0]  grant_q, grant_d;
    logic [N_PE-1:0]  done_q, done_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next;
    logic [LEN_W-1:0] remain_q, remain_d;

    logic [N_PE-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic [LEN_W-1:0] pick_len;
    logic [1:0]       beats;
    logic [LEN_W-1:0] beats_ext;
    logic             req_held;
    logic             release_grant;

`ifdef CV_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick #(
        .N_PE  (N_PE),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .sel_oh    (pick_oh),
        .sel_idx   (pick_idx),
        .sel_valid (pick_valid)
    );

    // Forward the granted PE's channels; everything reads zero without a grant.
    always_comb begin
        wvalid = 1'b0;
        waddr  = '0;
        wdata  = '0;
        rvalid = 1'b0;
        raddr  = '0;
        for (int unsigned i = 0; i < N_PE; i++) begin
            if (grant_q[i]) begin
                wvalid = pe_wvalid[i];
                waddr  = pe_waddr[i*MEM_ADDR_W +: MEM_ADDR_W];
                wdata  = pe_wdata[i*MEM_DATA_W +: MEM_DATA_W];
                rvalid = pe_rvalid[i];
                raddr  = pe_raddr[i*MEM_ADDR_W +: MEM_ADDR_W];
            end
        end
    end

    // Burst length of the PE the picker would grant this cycle.
    always_comb begin
        pick_len = '0;
        for (int unsigned i = 0; i < N_PE; i++) begin
            if (pick_oh[i]) begin
                pick_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign pe_wready = grant_q & {N_PE{wready}};
    assign pe_rready = grant_q & {N_PE{rready}};
    assign pe_rdata  = rdata;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = |grant_q;

    assign beats     = {1'b0, wvalid & wready} + {1'b0, rvalid & rready};
    assign beats_ext = LEN_W'(beats);
    assign req_held  = |(req & grant_q);
    assign ptr_next  = (gidx_q == PTR_W'(N_PE - 1)) ? '0 : gidx_q + PTR_W'(1);

    // Next-state: grant on request, count beats, release on completion/abort/timeout.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        remain_d      = remain_q;
        ptr_d         = ptr_q;
        done_d        = '0;
        release_grant = 1'b0;
`ifdef CV_ARB_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_GRANT;
                    grant_d  = pick_oh;
                    gidx_d   = pick_idx;
                    remain_d = pick_len;
`ifdef CV_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ARB_GRANT: begin
                // Abort outranks completion: an in-flight beat is forwarded, not counted.
                if (!req_held) begin
                    release_grant = 1'b1;
                end else if (beats_ext >= remain_q) begin
                    release_grant = 1'b1;
                    done_d        = grant_q;
`ifdef CV_ARB_TIMEOUT_EN
                end else if (beats == 2'd0 && idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    release_grant = 1'b1;
                    timeout_d     = 1'b1;
`endif
                end else begin
                    remain_d = remain_q - beats_ext;
`ifdef CV_ARB_TIMEOUT_EN
                    idle_cnt_d = (beats != 2'd0) ? '0 : idle_cnt_q + TO_W'(1);
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
        if (release_grant) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            ptr_d   = ptr_next;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
        end
    end

`ifdef CV_ARB_TIMEOUT_EN
    // Idle-handshake counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cv_pe_arbiter.sv
// Self-checking bench for cv_pe_arbiter (4 PEs, 16-bit lengths, TIMEOUT=8).
module tb_cv_pe_arbiter;

    localparam int N  = 4;
    localparam int LW = 16;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]  pe_wvalid;
    logic [N*AW-1:0] pe_waddr;
    logic [N*DW-1:0] pe_wdata;
    logic [N-1:0]  pe_wready;
    logic [N-1:0]  pe_rvalid;
    logic [N*AW-1:0] pe_raddr;
    logic [N-1:0]  pe_rready;
    logic [DW-1:0] pe_rdata;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          timeout;
    logic          busy;
    logic          wvalid;
    logic          wready;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    int n_total = 0;
    int n_bad   = 0;
    int sb_grant[$];
    int sb_done[$];

    typedef struct {
        int pe;
        int len;
        bit wv;
        bit rv;
        bit wr;
        bit rr;
        int cyc;
    } vec_t;

    vec_t vecs[7];

    cv_pe_arbiter #(.N_PE(4), .LEN_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len),
        .pe_wvalid(pe_wvalid), .pe_waddr(pe_waddr), .pe_wdata(pe_wdata), .pe_wready(pe_wready),
        .pe_rvalid(pe_rvalid), .pe_raddr(pe_raddr), .pe_rready(pe_rready), .pe_rdata(pe_rdata),
        .grant(grant), .done(done), .timeout(timeout), .busy(busy),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] exp_waddr(input int i);
        return AW'(32'h0010_0000 + i * 32'h100);
    endfunction
    function automatic logic [AW-1:0] exp_raddr(input int i);
        return AW'(32'h0020_0000 + i * 32'h100);
    endfunction
    function automatic logic [DW-1:0] exp_wdata(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req       = '0;
        req_len   = '0;
        pe_wvalid = '0;
        pe_rvalid = '0;
        wready    = 1'b0;
        rready    = 1'b0;
    endtask

    task automatic start_pe(input int pe, input int len, input bit wv, input bit rv);
        req[pe]                = 1'b1;
        req_len[pe*LW +: LW]   = LW'(len);
        pe_wvalid[pe]          = wv;
        pe_rvalid[pe]          = rv;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_wvalid"}, 64'(wvalid), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_waddr"}, 64'(waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_raddr"}, 64'(raddr), 64'd0);
        chk({tag, "_pe_wready"}, 64'(pe_wready), 64'd0);
        chk({tag, "_pe_rready"}, 64'(pe_rready), 64'd0);
    endtask

    task automatic sb_pop_done(input string tag);
        int e;
        if (sb_done.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: done scoreboard empty", tag);
        end else begin
            e = sb_done.pop_front();
            chk(tag, 64'(done), 64'd1 << e);
        end
    endtask

    // Watch for new grants, popping the expected owner for each one.
    task automatic watch_grants(input int n, input int budget);
        int seen;
        int idle_run;
        bit had_grant;
        int e;
        logic [N-1:0] prev;
        seen      = 0;
        idle_run  = 0;
        prev      = grant;
        had_grant = (grant != '0);
        for (int c = 0; c < budget && seen < n; c++) begin
            tick();
            settle();
            if (grant != '0 && grant != prev) begin
                if (had_grant) chk("idle_gap", 64'(idle_run), 64'd1);
                e = sb_grant.pop_front();
                chk("grant_order", 64'(grant), 64'd1 << e);
                seen++;
                had_grant = 1'b1;
            end
            if (grant == '0) idle_run++;
            else idle_run = 0;
            prev = grant;
        end
        if (seen < n) begin
            n_total++;
            n_bad++;
            $display("FAIL watch_grants: saw %0d grants expected %0d", seen, n);
        end
    endtask

    task automatic drain();
        clear_inputs();
        for (int c = 0; c < 10 && grant != '0; c++) begin
            tick();
            settle();
        end
        chk("drain_idle", 64'(grant), 64'd0);
        tick();
        settle();
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int held;
        vecs[0] = '{2, 3, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vecs[1] = '{1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[2] = '{3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[3] = '{0, 5, 1'b1, 1'b1, 1'b1, 1'b1, 3};
        vecs[4] = '{1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 4};
        vecs[5] = '{3, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[6] = '{0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 3};

        rst = 1'b1;
        clear_inputs();
        rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            pe_waddr[i*AW +: AW] = exp_waddr(i);
            pe_raddr[i*AW +: AW] = exp_raddr(i);
            pe_wdata[i*DW +: DW] = exp_wdata(i);
        end
        tick();
        tick();
        settle();
        chk_zero("reset");
        chk("pe_rdata", 64'(pe_rdata), 64'hDEAD_BEEF);
        rst = 1'b0;

        // Table-driven single bursts.
        for (int v = 0; v < 7; v++) begin
            tick();
            start_pe(vecs[v].pe, vecs[v].len, vecs[v].wv, vecs[v].rv);
            wready = vecs[v].wr;
            rready = vecs[v].rr;
            sb_done.push_back(vecs[v].pe);
            tick();
            settle();
            chk("vec_grant", 64'(grant), 64'd1 << vecs[v].pe);
            chk("vec_busy", 64'(busy), 64'd1);
            chk("vec_wvalid", 64'(wvalid), 64'(vecs[v].wv));
            chk("vec_rvalid", 64'(rvalid), 64'(vecs[v].rv));
            chk("vec_waddr", 64'(waddr), 64'(exp_waddr(vecs[v].pe)));
            chk("vec_wdata", 64'(wdata), 64'(exp_wdata(vecs[v].pe)));
            chk("vec_raddr", 64'(raddr), 64'(exp_raddr(vecs[v].pe)));
            chk("vec_pe_wready", 64'(pe_wready), vecs[v].wr ? (64'd1 << vecs[v].pe) : 64'd0);
            chk("vec_pe_rready", 64'(pe_rready), vecs[v].rr ? (64'd1 << vecs[v].pe) : 64'd0);
            n = 0;
            while (grant != '0 && n < 50) begin
                n++;
                tick();
                settle();
            end
            chk("vec_cycles", 64'(n), 64'(vecs[v].cyc));
            sb_pop_done("vec_done");
            clear_inputs();
        end

        // Fairness: all four request from reset.
        drain();
        pulse_reset();
        for (int i = 0; i < N; i++) start_pe(i, 2, 1'b0, 1'b1);
        rready = 1'b1;
        sb_grant.push_back(0);
        sb_grant.push_back(1);
        sb_grant.push_back(2);
        sb_grant.push_back(3);
        sb_grant.push_back(0);
        watch_grants(5, 40);
        drain();

        // Pointer wrap: PE1 holds, PE0 and PE3 wait; PE3 goes next.
        start_pe(1, 2, 1'b0, 1'b1);
        sb_grant.push_back(1);
        watch_grants(1, 5);
        tick();
        start_pe(0, 1, 1'b0, 1'b1);
        start_pe(3, 1, 1'b0, 1'b1);
        tick();
        settle();
        chk("wrap_hold", 64'(grant), 64'b0010);
        rready = 1'b1;
        sb_grant.push_back(3);
        sb_grant.push_back(0);
        watch_grants(2, 20);
        drain();

        // Backpressure: wready low for 5 cycles after the first beat.
        start_pe(1, 4, 1'b1, 1'b0);
        wready = 1'b1;
        sb_done.push_back(1);
        tick();
        settle();
        chk("bp_grant", 64'(grant), 64'b0010);
        tick();
        wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_hold_grant", 64'(grant), 64'b0010);
            chk("bp_waddr", 64'(waddr), 64'(exp_waddr(1)));
            chk("bp_wdata", 64'(wdata), 64'(exp_wdata(1)));
            chk("bp_pe_wready", 64'(pe_wready), 64'd0);
            tick();
        end
        wready = 1'b1;
        settle();
        n = 0;
        while (grant != '0 && n < 20) begin
            n++;
            tick();
            settle();
        end
        chk("bp_remaining_cycles", 64'(n), 64'd3);
        sb_pop_done("bp_done");
        drain();

        // Reset in the middle of a burst.
        start_pe(2, 10, 1'b1, 1'b1);
        rready = 1'b1;
        tick();
        settle();
        chk("rst_pre_grant", 64'(grant), 64'b0100);
        tick();
        rst = 1'b1;
        tick();
        settle();
        chk_zero("midrst");
        rst = 1'b0;
        clear_inputs();
        tick();
        settle();
        chk("midrst_no_done", 64'(done), 64'd0);

        // Abort: PE0 drops req after one of four beats; PE2 is served next.
        tick();
        start_pe(0, 4, 1'b0, 1'b1);
        start_pe(2, 1, 1'b0, 1'b1);
        rready = 1'b1;
        sb_done.push_back(2);
        tick();
        settle();
        chk("abort_grant0", 64'(grant), 64'b0001);
        chk("abort_beat1", 64'(pe_rready), 64'b0001);
        tick();
        req[0] = 1'b0;
        settle();
        chk("abort_inflight_grant", 64'(grant), 64'b0001);
        chk("abort_inflight_ready", 64'(pe_rready), 64'b0001);
        tick();
        settle();
        chk("abort_released", 64'(grant), 64'd0);
        chk("abort_no_done", 64'(done), 64'd0);
        tick();
        settle();
        chk("abort_next_grant", 64'(grant), 64'b0100);
        tick();
        settle();
        sb_pop_done("abort_next_done");
        chk("abort_next_grant_clear", 64'(grant), 64'd0);
        drain();

        // Timeout: memory never ready.
        start_pe(3, 5, 1'b1, 1'b1);
        tick();
        settle();
        chk("to_grant", 64'(grant), 64'b1000);
`ifdef CV_ARB_TIMEOUT_EN
        n = 0;
        while (grant != '0 && n < 50) begin
            n++;
            tick();
            settle();
        end
        chk("to_cycles", 64'(n), 64'd8);
        chk("to_pulse", 64'(timeout), 64'd1);
        chk("to_no_done", 64'(done), 64'd0);
        tick();
        settle();
        chk("to_pulse_end", 64'(timeout), 64'd0);
`else
        held = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            settle();
            if (grant == 4'b1000 && timeout == 1'b0 && done == '0) held++;
        end
        chk("to_hold_cycles", 64'(held), 64'd120);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cv_pe_arbiter.md
# cv_pe_arbiter

Round-robin arbiter that shares the single Genie external memory port (read and write channels) among `N_PE` convolution PE data loaders. It sits between the per-PE CV loader/core instances and the layer-type memory mux. It grants one PE at a time for a declared burst of memory beats and returns the grant when the burst completes, aborts or (optionally) times out.

## Interface
- `N_PE`, 4: number of requesting PEs (2..16)
- `LEN_W`, 16: width of the per-request burst length
- `TIMEOUT`, 1024: idle-handshake cycles before forced release (used only with the macro)

- `clk` in 1: clock
- `rst` in 1: reset; one clock, synchronous, active-high
- `req` in N_PE: per-PE request, held until done/abort
- `req_len` in N_PE*LEN_W: flattened burst lengths in beats, PE i at `[i*LEN_W +: LEN_W]`, sampled at grant
- `pe_wvalid` in N_PE; `pe_waddr` in N_PE*26; `pe_wdata` in N_PE*32: per-PE write channel
- `pe_wready` out N_PE: write beat accepted, granted PE only
- `pe_rvalid` in N_PE; `pe_raddr` in N_PE*26: per-PE read-request channel
- `pe_rready` out N_PE: read data valid, granted PE only
- `pe_rdata` out 32: broadcast of `rdata`
- `grant` out N_PE: one-hot registered grant
- `done` out N_PE: one-cycle pulse when PE i's burst completes
- `timeout` out 1: one-cycle pulse on forced release (0 without macro)
- `busy` out 1: any grant active
- `wvalid` out 1, `wready` in 1, `waddr` out 26, `wdata` out 32: memory write port
- `rvalid` out 1, `rready` in 1, `raddr` out 26, `rdata` in 32: memory read port

## Operation
- States: IDLE, GRANT.
- IDLE: if `req != 0`, choose the first set bit at or above `ptr`, wrapping around. Load `grant` one-hot, `remain = req_len[sel]`, go to GRANT. `ptr` resets to 0.
- GRANT:
  - Memory outputs are driven combinationally from the granted PE's channel.
  - `pe_wready[g] = wready`, `pe_rready[g] = rready`. All non-granted ready bits are 0.
  - Beats per cycle = (wvalid&wready) + (rvalid&rready), giving 0, 1 or 2.
  - If beats >= remain: pulse `done[g]`, clear grant, set `ptr = g+1 mod N_PE`, go to IDLE.
  - Otherwise: `remain -= beats`.
- `req_len == 0`: the grant lasts one cycle, then releases with a `done` pulse. Any handshake in that cycle is still forwarded.
- Abort: if `req[g]` drops while in GRANT, release the next cycle. No `done` pulse. `ptr` advances. A beat already in flight in that cycle is forwarded but not counted.
- With no grant, `wvalid`, `rvalid`, `waddr`, `wdata` and `raddr` are 0.
- `req_len` changes during a grant are ignored.

## Timing
- Reset values: `grant`, `done`, `pe_wready`, `pe_rready`, `wvalid`, `rvalid`, `waddr`, `wdata`, `raddr`, `timeout`, `busy` are all 0; `remain=0`, `ptr=0`, state IDLE.
- Request to grant: `req` high at cycle t gives `grant` at t+1. The first forwarded beat can occur at t+1.
- Release: the last beat at cycle t gives `done` high during t+1 with `grant` already 0. The earliest next grant is t+2, so there is one mandatory IDLE cycle between bursts.
- Memory-side valid/addr/data are combinational from the granted PE's inputs. The PE must hold them stable until its ready bit is set (backpressure passthrough).
- `rst` mid-grant: everything returns to reset values the next cycle. No `done` is pulsed.

## Configuration
- `CV_ARB_TIMEOUT_EN` defined:
  - A counter clears on every forwarded handshake and on every new grant, and increments in GRANT otherwise.
  - When it reaches `TIMEOUT`: release the grant, pulse `timeout`, no `done`, advance `ptr`.
- Undefined: there is no counter, `timeout` is tied to 0, and a grant is held indefinitely.

## Structure
- Shared package / constants file holds `MEM_ADDR_W=26`, `MEM_DATA_W=32` and the state encoding `ARB_IDLE` / `ARB_GRANT`.
- Sub-module `rr_pick`: combinational, takes `req`, `ptr` and `N_PE`, returns a one-hot selection and its index.
- The beat counter and timeout logic stay in the top module.

## Test plan
- Single read burst: PE2 `req` with `req_len=3`, `rready` high every cycle → `grant=4'b0100` the cycle after `req`, three `pe_rready[2]` beats, then `done[2]` pulse with grant 0.
- Fairness: all four PEs request with length 2 after reset → grants in order 0, 1, 2, 3, then 0, each separated by one idle cycle.
- Pointer wrap: PE1 holds a grant while PE0 and PE3 request → next grant PE3, then PE0.
- Backpressure and dual beats:
  - `wready` low for 5 cycles mid-burst → `remain` holds, `waddr`/`wdata` stable.
  - Simultaneous read and write beats with `remain=2` → `done` in one cycle.
- Abort and reset:
  - PE0 drops `req` after 1 of 4 beats → grant released, no `done`, next requester served.
  - `rst` asserted mid-burst → all outputs 0 the next cycle.
- Timeout: macro defined, `TIMEOUT=8`, memory never ready → `timeout` pulses after 8 granted cycles and grant is cleared. Without the macro the grant holds for 100+ cycles.
